// File: rtl/user_io_pkg.sv
// Shared constants, FSM state type and response packing for the user IO responder.
// Lane layout: uout {VALID, WRITE, payload}, uin {ACK, ERR, data}.
package user_io_pkg;

  localparam int VALID_BIT = 15;
  localparam int WRITE_BIT = 14;
  localparam int ACK_BIT   = 15;
  localparam int ERR_BIT   = 14;
  localparam int DATA_W    = 14;
  localparam int ADDR_W    = 4;
  localparam logic [ADDR_W-1:0] ID_ADDR = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACK,
    WR_HACK,
    WR_DATA,
    WR_DACK
  } state_t;

  function automatic logic [15:0] ack_word(
    input logic              err,
    input logic [DATA_W-1:0] data
  );
    logic [15:0] w;
    w          = '0;
    w[ACK_BIT] = 1'b1;
    w[ERR_BIT] = err;
    w[DATA_W-1:0] = data;
    return w;
  endfunction

endpackage

// File: rtl/user_io_regfile.sv
// NUM_REGS x 14-bit register file: one write port, combinational read mux,
// flattened contents on q.
module user_io_regfile
  import user_io_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] q
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (waddr == ADDR_W'(i))
          regs[i] <= wdata;
    end
  end

  // Out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (raddr == ADDR_W'(i))
        rdata = regs[i];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: rtl/user_io_responder.sv
// 4-phase register-access responder on the 16-lane user/fabric IO tile.
// USER_IO_RESPONDER_SYNC_EN adds a 2-flop input stage on uout (ACK latency 3).
module user_io_responder
  import user_io_pkg::*;
#(
  parameter int                NUM_REGS = 8,
  parameter logic [DATA_W-1:0] ID_VALUE = 14'h2A5
) (
  input  logic                       UserCLK,
  input  logic                       rst,
  input  logic [15:0]                uout,
  output logic [15:0]                uin,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr
);

  logic [15:0] u;

`ifdef USER_IO_RESPONDER_SYNC_EN
  logic [15:0] s1_q;
  logic [15:0] s2_q;

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= uout;
      s2_q <= s1_q;
    end
  end

  assign u = s2_q;
`else
  assign u = uout;
`endif

  state_t              state_q, state_d;
  logic [15:0]         uin_q, uin_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                stb_q;
  logic [ADDR_W-1:0]   waddr_q;

  logic                vld;
  logic                hw;
  logic [ADDR_W-1:0]   ha;
  logic                ok;
  logic                we;
  logic [DATA_W-1:0]   rdata;
  logic [DATA_W-1:0]   rd_val;

  assign vld = u[VALID_BIT];
  assign hw  = u[WRITE_BIT];
  assign ha  = u[ADDR_W-1:0];
  assign ok  = (ha < ADDR_W'(NUM_REGS)) ||
               (ha == ID_ADDR && !hw);

  assign rd_val = !ok             ? '0 :
                  (ha == ID_ADDR) ? ID_VALUE :
                                    rdata;

  user_io_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk   (UserCLK),
    .rst   (rst),
    .we    (we),
    .waddr (addr_q),
    .wdata (u[DATA_W-1:0]),
    .raddr (ha),
    .rdata (rdata),
    .q     (reg_q)
  );

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state_q <= IDLE;
      uin_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      uin_q   <= uin_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      stb_q   <= we;
      if (we)
        waddr_q <= addr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    uin_d   = uin_q;
    addr_d  = addr_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vld) begin
          addr_d = ha;
          err_d  = !ok;
          if (hw) begin
            uin_d   = ack_word(!ok, '0);
            state_d = WR_HACK;
          end else begin
            uin_d   = ack_word(!ok, rd_val);
            state_d = RD_ACK;
          end
        end
      end
      RD_ACK: begin
        if (!vld) begin
          uin_d   = '0;
          state_d = IDLE;
        end
      end
      WR_HACK: begin
        if (!vld) begin
          uin_d   = '0;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        // Errored writes still consume the data word.
        if (vld) begin
          we      = !err_q;
          uin_d   = ack_word(err_q, '0);
          state_d = WR_DACK;
        end
      end
      WR_DACK: begin
        if (!vld) begin
          uin_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        uin_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign uin     = uin_q;
  assign wr_stb  = stb_q;
  assign wr_addr = waddr_q;

endmodule

// File: doc/user_io_responder.md
Name: user_io_responder

Overview:
- User-project-side endpoint of the 16-lane user/fabric IO tile. Consumes the fabric-driven UOUT lanes and drives the UIN lanes back to the fabric.
- Implements a 4-phase register-access responder: the fabric design is the initiator, this block owns a small register file.
- Gives fabric soft logic read/write control of user-project configuration and status over the existing 16 lanes.

Parameters:
- NUM_REGS, 8, number of read/write 14-bit registers (1..15), addresses 0..NUM_REGS-1.
- ID_VALUE, 14'h2A5, constant returned by a read of address 15.

Ports:
- UserCLK  input  1  block clock; the fabric initiator is on the same clock.
- rst  input  1  synchronous active-high reset.
- uout  input  16  lanes from fabric (UOUT0..15): [15] VALID, [14] WRITE, [13:0] payload.
- uin  output  16  lanes to fabric (UIN0..15): [15] ACK, [14] ERR, [13:0] read data.
- reg_q  output  NUM_REGS*14  flattened register contents; reg n at [n*14+13:n*14].
- wr_stb  output  1  one-cycle pulse when a register is written.
- wr_addr  output  4  address of the last write; valid with wr_stb.

Behaviour:
- Interface: one clock, UserCLK. Reset rst is synchronous, active-high.
- Reset values: uin=0, reg_q=0, wr_stb=0, wr_addr=0, state=IDLE.
- All outputs are registered.
- 4-phase handshake:
  - Initiator raises VALID with a word and holds it stable.
  - Responder raises ACK.
  - Initiator drops VALID.
  - Responder drops ACK.
- Header word: WRITE=uout[14], address=uout[3:0]; uout[13:4] ignored.
- Address valid if addr<NUM_REGS, or (addr==15 and read).
- State IDLE: on VALID=1, latch the header.
  - Read: next cycle drive ACK=1, ERR=!valid, data=reg[addr], or ID_VALUE for addr 15, or 0 on error. Go to RD_ACK.
  - Write: next cycle ACK=1, ERR=!valid (write to 15 is an error), data=0. Go to WR_HACK.
- State RD_ACK: hold uin. On VALID=0, next cycle uin=0, go to IDLE.
- State WR_HACK: on VALID=0, uin=0, go to WR_DATA.
- State WR_DATA: on VALID=1, capture uout[13:0].
  - If the address was valid: update reg[addr], pulse wr_stb, set wr_addr.
  - Always: ACK=1, ERR as for the header. Go to WR_DACK.
  - The register update and wr_stb occur in the same cycle ACK rises.
- State WR_DACK: on VALID=0, uin=0, go to IDLE.
- Latency: ACK rises 1 cycle after VALID is sampled high, and falls 1 cycle after VALID is sampled low.
- uin[13:0] is zero whenever ACK=0.
- An errored write consumes its data word but does not modify any register.
- VALID held high indefinitely: responder holds ACK with no timeout.
- WRITE lane during data words and ACK phases: ignored.
- rst asserted mid-transaction: the transaction is abandoned, registers are cleared, and the state returns to IDLE with ACK=0. If VALID is still high after reset, it is treated as a new header.
- Illegal state encodings: go to IDLE.

Optional Feature:
- Macro USER_IO_RESPONDER_SYNC_EN.
- Defined: uout passes through a 2-flop register stage before the FSM, for long fabric routes. ACK latency becomes 3 cycles after VALID; the handshake is otherwise unchanged. Reset clears both stages.
- Undefined: uout is sampled directly; latency is 1 cycle.

Decomposition:
- Package user_io_pkg holds:
  - lane index constants: VALID_BIT=15, WRITE_BIT=14, ACK_BIT=15, ERR_BIT=14, DATA_W=14, ADDR_W=4, ID_ADDR=15;
  - FSM state enum: IDLE, RD_ACK, WR_HACK, WR_DATA, WR_DACK.
- One sub-module user_io_regfile: NUM_REGS x 14 storage with a write port and a combinational read mux.

Test Plan:
- Reset, then read addr 0 -> ACK=1 one cycle after VALID, ERR=0, data=0; ACK=0 one cycle after VALID drops.
- Write header addr 3, data 14'h1234 -> wr_stb single pulse with wr_addr=3; reg_q[55:42]=14'h1234; a subsequent read of addr 3 returns 14'h1234.
- Read addr 15 -> data=14'h2A5, ERR=0; write addr 15 or addr 9 (NUM_REGS=8) -> ERR=1 on both ACKs, no wr_stb, all registers unchanged.
- Hold VALID high 20 cycles on a read -> ACK stays 1 and data stays stable; uin[13:0]=0 after ACK drops.
- Assert rst in WR_DATA after a header to addr 2 -> uin=0, reg_q=0; the next header is handled from IDLE.
- Build with USER_IO_RESPONDER_SYNC_EN and repeat the first scenario -> ACK rises 3 cycles after VALID, with identical data.
